logical_eq_frame_accumulator: RTL

//  Downstream consumer of the per-beat logical-EQ result (c = ~(|a ^ |b)).

---
 rtl/logical_pkg.sv | 13 +
 rtl/logical_eq_frame_accumulator_sat_counter.sv | 33 +++
 rtl/logical_eq_frame_accumulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/logical_pkg.sv
// Shared types and defaults for the logical-EQ frame accumulator.
// The state encoding is fixed so that other blocks decoding it stay consistent.
package logical_pkg;

  localparam int unsigned LEQ_CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    LEQ_IDLE  = 2'b00,
    LEQ_ACCUM = 2'b01,
    LEQ_HOLD  = 2'b10
  } leq_state_t;

endpackage

// File: rtl/logical_eq_frame_accumulator_sat_counter.sv
// Saturating up-counter. When the count is at its maximum it holds that value,
// and `sat` stays high so the parent can flag an overflow.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q, count_d;

  assign sat   = (count_q == CNT_MAX);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear)            count_d = '0;
    else if (inc && !sat) count_d = count_q + 1'b1;
  end

  // NOTE: state registers take non-blocking assignments, so every flop samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/logical_eq_frame_accumulator.sv
// Collects per-beat logical-EQ results into frames that end on eq_last.
// Emits one summary per frame (all-equal, mismatch count, beat count, overflow) through a valid/ready handshake.
module logical_eq_frame_accumulator
  import logical_pkg::*;
#(
  parameter int unsigned CW = LEQ_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          eq_valid,
  output logic          eq_ready,
  input  logic          eq_c,
  input  logic          eq_last,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          sum_all_eq,
  output logic [CW-1:0] sum_mismatch_cnt,
  output logic [CW-1:0] sum_beat_cnt,
  output logic          sum_overflow
);

  leq_state_t    state_q, state_d;
  logic          beat_acc, last_acc, handoff, mism_inc;
  logic [CW-1:0] beat_cnt, mism_cnt, beat_nxt, mism_nxt;
  logic          beat_sat, mism_sat, ovf_hit;
  logic          ovf_q, ovf_d;
  logic          all_eq_q, all_eq_d, sum_ovf_q, sum_ovf_d;
  logic [CW-1:0] sum_beat_q, sum_beat_d, sum_mism_q, sum_mism_d;

  // eq_ready depends only on rst and the state register, never on sum_ready.
  assign eq_ready  = !rst && (state_q != LEQ_HOLD);
  assign sum_valid = (state_q == LEQ_HOLD);
  assign beat_acc  = eq_valid && eq_ready;
  assign last_acc  = beat_acc && eq_last;
  assign handoff   = sum_valid && sum_ready;
  assign mism_inc  = beat_acc && !eq_c;

  sat_counter #(.W(CW)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (handoff),
    .inc   (beat_acc),
    .count (beat_cnt),
    .sat   (beat_sat)
  );

  sat_counter #(.W(CW)) u_mism_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (handoff),
    .inc   (mism_inc),
    .count (mism_cnt),
    .sat   (mism_sat)
  );

  // Post-beat counter values, so that the summary includes the last beat.
  assign beat_nxt = beat_sat ? beat_cnt : beat_cnt + 1'b1;
  assign mism_nxt = (eq_c || mism_sat) ? mism_cnt : mism_cnt + 1'b1;
  assign ovf_hit  = beat_acc && (beat_sat || (!eq_c && mism_sat));
  assign ovf_d    = handoff ? 1'b0 : (ovf_q || ovf_hit);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEQ_IDLE, LEQ_ACCUM: if (beat_acc) state_d = eq_last ? LEQ_HOLD : LEQ_ACCUM;
      LEQ_HOLD:            if (sum_ready) state_d = LEQ_IDLE;
      default:             state_d = LEQ_IDLE;
    endcase
  end

  always_comb begin
    all_eq_d   = all_eq_q;
    sum_beat_d = sum_beat_q;
    sum_mism_d = sum_mism_q;
    sum_ovf_d  = sum_ovf_q;
    if (last_acc) begin
      all_eq_d   = (mism_nxt == '0);
      sum_beat_d = beat_nxt;
      sum_mism_d = mism_nxt;
      sum_ovf_d  = ovf_q || ovf_hit;
    end else if (handoff) begin
      all_eq_d   = 1'b0;
      sum_beat_d = '0;
      sum_mism_d = '0;
      sum_ovf_d  = 1'b0;
    end
  end

  // NOTE: reset is synchronous; a reset mid-frame or in HOLD drops all partial and pending results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LEQ_IDLE;
      ovf_q      <= 1'b0;
      all_eq_q   <= 1'b0;
      sum_beat_q <= '0;
      sum_mism_q <= '0;
      sum_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      all_eq_q   <= all_eq_d;
      sum_beat_q <= sum_beat_d;
      sum_mism_q <= sum_mism_d;
      sum_ovf_q  <= sum_ovf_d;
    end
  end

  assign sum_all_eq       = all_eq_q;
  assign sum_mismatch_cnt = sum_mism_q;
  assign sum_beat_cnt     = sum_beat_q;
  assign sum_overflow     = sum_ovf_q;

endmodule
